// File: rtl/reset_nmi_ctrl.sv
// Turns debounced keyboard f12/f11/f5 requests into timed CPU reset, boot-select and NMI controls.
// Define RESET_DEBOUNCE_EN for counter debouncing; otherwise inputs use a 2-stage ce-sampled synchronizer.
module reset_nmi_ctrl #(
    parameter int DEBOUNCE   = 4096,
    parameter int RST_CYCLES = 1024,
    parameter int NMI_CYCLES = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic f12,
    input  logic f11,
    input  logic f5,
    output logic rst_n,
    output logic nmi_n,
    output logic boot,
    output logic busy
);

    localparam int MAX_CYCLES = (RST_CYCLES > NMI_CYCLES) ? RST_CYCLES : NMI_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_HOLD,
        S_NMI,
        S_NMI_WAIT
    } state_t;

    typedef enum logic [1:0] {
        TRG_NONE,
        TRG_F12,
        TRG_F11
    } trig_t;

    if (DEBOUNCE < 1 || RST_CYCLES < 1 || NMI_CYCLES < 1) begin : g_param_check
        $error("reset_nmi_ctrl: DEBOUNCE, RST_CYCLES and NMI_CYCLES must all be >= 1");
    end

    // Bit order: [2]=f12, [1]=f11, [0]=f5
    logic [2:0] req_in;
    logic [2:0] db_q, db_d;
    logic [2:0] fall;

    assign req_in = {f12, f11, f5};

`ifdef RESET_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

    logic [2:0][DW-1:0] dcnt_q, dcnt_d;

    // A new level must persist for DEBOUNCE consecutive ce ticks before it is accepted.
    always_comb begin
        dcnt_d = dcnt_q;
        db_d   = db_q;
        if (ce) begin
            for (int i = 0; i < 3; i++) begin
                if (req_in[i] == db_q[i]) begin
                    dcnt_d[i] = '0;
                end else if (dcnt_q[i] >= DB_LAST) begin
                    db_d[i]   = req_in[i];
                    dcnt_d[i] = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dcnt_q <= '0;
            db_q   <= 3'b111;
        end else begin
            dcnt_q <= dcnt_d;
            db_q   <= db_d;
        end
    end
`else
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = sync_q;
        db_d   = db_q;
        if (ce) begin
            sync_d = req_in;
            db_d   = sync_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 3'b111;
            db_q   <= 3'b111;
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
        end
    end
`endif

    // Events fire on the tick the debounced level drops, so the FSM reacts without extra delay.
    assign fall = db_q & ~db_d;

    state_t        state_q, state_d;
    trig_t         trig_q, trig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          boot_q, boot_d;
    logic          rst_n_q, rst_n_d;
    logic          nmi_n_q, nmi_n_d;
    logic          busy_q, busy_d;
    logic          rst_req;
    logic          trig_low;

    assign rst_req = fall[2] | fall[1];

    always_comb begin
        case (trig_q)
            TRG_F12: trig_low = ~db_q[2];
            TRG_F11: trig_low = ~db_q[1];
            default: trig_low = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        trig_d  = trig_q;
        cnt_d   = cnt_q;
        boot_d  = boot_q;
        if (ce) begin
            case (state_q)
                S_IDLE, S_NMI, S_NMI_WAIT: begin
                    if (rst_req) begin
                        state_d = S_RESET;
                        cnt_d   = CW'(RST_CYCLES);
                        trig_d  = fall[2] ? TRG_F12 : TRG_F11;
                        boot_d  = ~fall[2];
                    end else if (state_q == S_IDLE) begin
                        if (fall[0]) begin
                            state_d = S_NMI;
                            cnt_d   = CW'(NMI_CYCLES);
                        end
                    end else if (state_q == S_NMI) begin
                        if (cnt_q <= CW'(1)) begin
                            state_d = S_NMI_WAIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end else if (db_q[0]) begin
                        state_d = S_IDLE;
                    end
                end
                S_RESET: begin
                    if (cnt_q <= CW'(1)) begin
                        cnt_d   = '0;
                        state_d = trig_low ? S_HOLD : S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (!trig_low) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        rst_n_d = ~((state_d == S_RESET) || (state_d == S_HOLD));
        nmi_n_d = (state_d != S_NMI);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RESET;
            trig_q  <= TRG_NONE;
            cnt_q   <= CW'(RST_CYCLES);
            boot_q  <= 1'b0;
            rst_n_q <= 1'b0;
            nmi_n_q <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
            rst_n_q <= rst_n_d;
            nmi_n_q <= nmi_n_d;
            busy_q  <= busy_d;
        end
    end

    assign rst_n = rst_n_q;
    assign nmi_n = nmi_n_q;
    assign boot  = boot_q;
    assign busy  = busy_q;

endmodule
